// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, legality check and the sharing FSM state type.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SGE = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic alu_ctrl_legal(input logic [CTRL_W-1:0] code);
    logic ok;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SGE,
      ALU_SUB, ALU_SLT, ALU_NOR: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves only when the grant is actually taken by a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant_q <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between execute (req 0) and branch-compare (req 1),
// with a registered response buffer held until the owner accepts it.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_BITS  = CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_a0,
  input  logic [DATA_WIDTH-1:0] req_b0,
  input  logic [DATA_WIDTH-1:0] req_a1,
  input  logic [DATA_WIDTH-1:0] req_b1,
  input  logic [CTRL_BITS-1:0]  req_ctrl0,
  input  logic [CTRL_BITS-1:0]  req_ctrl1,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [CTRL_BITS-1:0]  alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_c,
  input  logic                  alu_zero,
  input  logic                  alu_over,
  input  logic                  alu_cout,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_c,
  output logic                  resp_zero,
  output logic                  resp_over,
  output logic                  resp_cout,
  output logic                  resp_illegal,
  output logic                  busy
);

  state_e state_q, state_d;

  logic [1:0]            grant;
  logic                  hs;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [CTRL_BITS-1:0]  ctrl_q;
  logic                  id_q;
  logic                  ctrl_ok;

  logic                  resp_valid_q, resp_id_q, busy_q;
  logic [DATA_WIDTH-1:0] resp_c_q;
  logic                  resp_zero_q, resp_over_q, resp_cout_q, resp_illegal_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (hs),
    .grant   (grant)
  );

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      id_q   <= 1'b0;
    end else if (hs) begin
      a_q    <= grant[1] ? req_a1    : req_a0;
      b_q    <= grant[1] ? req_b1    : req_b0;
      ctrl_q <= grant[1] ? req_ctrl1 : req_ctrl0;
      id_q   <= grant[1];
    end
  end

  // An illegal latched code is never presented to the ALU, in any state.
  assign ctrl_ok  = alu_ctrl_legal(ctrl_q);
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_ok ? ctrl_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_c_q       <= '0;
      resp_zero_q    <= 1'b0;
      resp_over_q    <= 1'b0;
      resp_cout_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_id_q      <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_c_q       <= ctrl_ok ? alu_c : '0;
      resp_zero_q    <= ctrl_ok ? alu_zero : 1'b1;
      resp_over_q    <= ctrl_ok & alu_over;
      resp_cout_q    <= ctrl_ok & alu_cout;
      resp_illegal_q <= ~ctrl_ok;
      resp_id_q      <= id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      resp_valid_q <= (state_d == RESP);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_c       = resp_c_q;
  assign resp_zero    = resp_zero_q;
  assign resp_over    = resp_over_q;
  assign resp_cout    = resp_cout_q;
  assign resp_illegal = resp_illegal_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: behavioural ALU on the alu_* ports, scoreboard of
// expected responses pushed at each handshake and popped when a response is consumed.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  typedef struct packed {
    logic        id;
    logic [31:0] c;
    logic        zero;
    logic        over;
    logic        cout;
    logic        illegal;
  } exp_t;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_over, alu_cout;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_c;
  logic        resp_zero, resp_over, resp_cout, resp_illegal, busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  logic model_last;
  logic [1:0] keep;
  exp_t sb[$];
  int   glog[$];
  int   gcyc[$];
  exp_t alu_r;

  alu_share_ctrl #(.DATA_WIDTH(32), .CTRL_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_c(alu_c), .alu_zero(alu_zero), .alu_over(alu_over), .alu_cout(alu_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_c(resp_c), .resp_zero(resp_zero), .resp_over(resp_over),
    .resp_cout(resp_cout), .resp_illegal(resp_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [32:0] s;
    r = '0;
    case (ctrl)
      ALU_AND: r.c = a & b;
      ALU_OR:  r.c = a | b;
      ALU_NOR: r.c = ~(a | b);
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.c = s[31:0]; r.cout = s[32];
        r.over = (a[31] == b[31]) && (r.c[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.c = s[31:0]; r.cout = s[32];
        r.over = (a[31] != b[31]) && (r.c[31] != a[31]);
      end
      ALU_SLT: r.c = {31'b0, ($signed(a) < $signed(b))};
      ALU_SGE: r.c = {31'b0, ($signed(a) >= $signed(b))};
      default: r.illegal = 1'b1;
    endcase
    r.zero = (r.c == 32'd0);
    return r;
  endfunction

  always_comb alu_r = ref_alu(alu_ctrl, alu_a, alu_b);
  assign alu_c    = alu_r.c;
  assign alu_zero = alu_r.zero;
  assign alu_over = alu_r.over;
  assign alu_cout = alu_r.cout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [3:0] rand_legal();
    logic [3:0] codes [7];
    codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SGE, ALU_SUB, ALU_SLT, ALU_NOR};
    return codes[$urandom_range(0, 6)];
  endfunction

  task automatic load_req(input int g);
    if (g == 0) begin
      req_a0 = $urandom; req_b0 = $urandom; req_ctrl0 = rand_legal();
    end else begin
      req_a1 = $urandom; req_b1 = $urandom; req_ctrl1 = rand_legal();
    end
  endtask

  // One clock: score this cycle's handshake/response, advance, then update requesters.
  task automatic step();
    logic [1:0] hs, exp_g;
    logic       fire;
    exp_t       e;
    int         g;
    #1;
    hs   = req_valid & req_ready;
    fire = resp_valid & resp_ready;
    g    = 0;
    if (fire) begin
      if (sb.size() == 0) begin
        chk("resp_without_request", resp_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_c", resp_c, e.c);
        chk("resp_zero", resp_zero, e.zero);
        chk("resp_over", resp_over, e.over);
        chk("resp_cout", resp_cout, e.cout);
        chk("resp_illegal", resp_illegal, e.illegal);
      end
    end
    if (hs != 2'b00) begin
      exp_g = (req_valid == 2'b11) ? (model_last ? 2'b01 : 2'b10) : req_valid;
      chk("grant", hs, exp_g);
      g = hs[1] ? 1 : 0;
      model_last = hs[1];
      e = (g == 0) ? ref_alu(req_ctrl0, req_a0, req_b0) : ref_alu(req_ctrl1, req_a1, req_b1);
      e.id = hs[1];
      sb.push_back(e);
      glog.push_back(g);
      gcyc.push_back(cycle);
    end
    @(posedge clk);
    cycle++;
    #1;
    if (hs != 2'b00) begin
      if (keep[g]) load_req(g);
      else req_valid[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (((req_valid != 2'b00) || (sb.size() != 0)) && (n < budget)) begin
      step();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    keep      = 2'b00;
    rst       = 1'b1;
    sb.delete();
    model_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] snap_c;
    logic [3:0]  snap_f;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0; keep = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_ctrl0 = '0; req_ctrl1 = '0;
    model_last = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_c", resp_c, 32'd0);
    chk("rst_flags", {resp_id, resp_zero, resp_over, resp_cout, resp_illegal}, 5'd0);
    chk("rst_alu_ops", {alu_a, alu_b, alu_ctrl}, 68'd0);
    @(negedge clk);
    rst = 1'b0;

    // Req0 ADD 5+7 with resp_ready held high.
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7; req_ctrl0 = ALU_ADD; resp_ready = 1'b1;
    #1 chk("t1_req_ready", req_ready, 2'b01);
    step();
    #1;
    chk("t1_exec_busy", busy, 1'b1);
    chk("t1_exec_resp_valid", resp_valid, 1'b0);
    chk("t1_alu_ops", {alu_a, alu_b, alu_ctrl}, {32'd5, 32'd7, ALU_ADD});
    step();
    #1;
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_resp_c", resp_c, 32'd12);
    step();
    #1;
    chk("t1_back_idle_valid", resp_valid, 1'b0);
    chk("t1_back_idle_busy", busy, 1'b0);

    // Both requesters continuously valid from a fresh reset: grants alternate 0,1,0,1.
    do_reset();
    glog.delete(); gcyc.delete();
    load_req(0); load_req(1);
    keep = 2'b11; req_valid = 2'b11; resp_ready = 1'b1;
    repeat (12) step();
    keep = 2'b00; req_valid = 2'b00;
    drain(10);
    chk("alt_count", glog.size(), 4);
    if (glog.size() >= 4) begin
      chk("alt_g0", glog[0], 0);
      chk("alt_g1", glog[1], 1);
      chk("alt_g2", glog[2], 0);
      chk("alt_g3", glog[3], 1);
      chk("alt_period", gcyc[1] - gcyc[0], 3);
    end

    // Req1 SUB overflow.
    req_valid = 2'b10; req_a1 = 32'h8000_0000; req_b1 = 32'd1; req_ctrl1 = ALU_SUB;
    step(); step();
    #1;
    chk("sub_c", resp_c, 32'h7FFF_FFFF);
    chk("sub_over", resp_over, 1'b1);
    chk("sub_id", resp_id, 1'b1);
    step(); step();

    // Illegal control code from req0.
    req_valid = 2'b01; req_a0 = 32'd3; req_b0 = 32'd5; req_ctrl0 = 4'b1111;
    step();
    #1 chk("ill_alu_ctrl", alu_ctrl, 4'b0000);
    step();
    #1;
    chk("ill_flag", resp_illegal, 1'b1);
    chk("ill_zero", resp_zero, 1'b1);
    chk("ill_c", resp_c, 32'd0);
    step(); step();

    // Response held with resp_ready low while req1 waits.
    resp_ready = 1'b0;
    req_valid = 2'b01; req_a0 = 32'd1; req_b0 = 32'd2; req_ctrl0 = ALU_ADD;
    step(); step();
    req_valid = 2'b10; req_a1 = 32'hF0; req_b1 = 32'h0F; req_ctrl1 = ALU_OR;
    snap_c = resp_c;
    snap_f = {resp_id, resp_zero, resp_over, resp_illegal};
    repeat (10) begin
      #1;
      chk("hold_req_ready", req_ready, 2'b00);
      chk("hold_busy", busy, 1'b1);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_c", resp_c, snap_c);
      chk("hold_flags", {resp_id, resp_zero, resp_over, resp_illegal}, snap_f);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1 chk("after_pulse_ready", req_ready, 2'b10);
    step();
    resp_ready = 1'b1;
    drain(10);

    // Reset during EXEC discards the operation and restores the arbiter pointer.
    req_valid = 2'b01; req_a0 = 32'd9; req_b0 = 32'd9; req_ctrl0 = ALU_SUB;
    step();
    rst = 1'b1;
    #1;
    chk("rstx_resp_valid", resp_valid, 1'b0);
    chk("rstx_busy", busy, 1'b0);
    chk("rstx_alu_a", alu_a, 32'd0);
    sb.delete();
    model_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      #1 chk("rstx_no_resp", resp_valid, 1'b0);
      step();
    end
    load_req(0); load_req(1);
    req_valid = 2'b11;
    #1 chk("rstx_first_grant", req_ready, 2'b01);
    drain(20);

    // Mixed random traffic with a random response back-pressure.
    for (int i = 0; i < 10; i++) begin
      load_req(0); load_req(1);
      req_valid = 2'($urandom_range(1, 3));
      for (int n = 0; (n < 40) && ((req_valid != 2'b00) || (sb.size() != 0)); n++) begin
        resp_ready = 1'($urandom_range(0, 1));
        step();
      end
      resp_ready = 1'b1;
      drain(10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
